// File: rtl/sd_slot_arbiter_if.sv
// Bundle of client-side request signals and the user_io SD block channel
// handled by sd_slot_arbiter; master is the arbiter, slave is its environment.
interface sd_slot_arbiter_if;
  logic [1:0]  req_rd;
  logic [1:0]  req_wr;
  logic [31:0] req_lba0;
  logic [31:0] req_lba1;
  logic [7:0]  buf_din0;
  logic [7:0]  buf_din1;
  logic [1:0]  busy;
  logic [1:0]  done;
  logic [1:0]  err;
  logic [1:0]  buf_wr;
  logic [31:0] sd_lba;
  logic [1:0]  sd_rd;
  logic [1:0]  sd_wr;
  logic        sd_ack;
  logic        sd_buff_wr;
  logic [7:0]  sd_buff_din;

  modport master (
    input  req_rd, req_wr, req_lba0, req_lba1, buf_din0, buf_din1,
    input  sd_ack, sd_buff_wr,
    output busy, done, err, buf_wr, sd_lba, sd_rd, sd_wr, sd_buff_din
  );

  modport slave (
    output req_rd, req_wr, req_lba0, req_lba1, buf_din0, buf_din1,
    output sd_ack, sd_buff_wr,
    input  busy, done, err, buf_wr, sd_lba, sd_rd, sd_wr, sd_buff_din
  );
endinterface

// File: rtl/sd_slot_arbiter.sv
// Round-robin arbiter sharing the user_io SD sector channel between two image
// slots: one whole-sector transaction at a time, with optional ack timeout.
module sd_slot_arbiter #(
  parameter int TIMEOUT = 28000000,
  parameter int TW      = 25
) (
  input logic                clk_sys,
  input logic                reset,
  sd_slot_arbiter_if.master  bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_XFER  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam bit            TO_EN   = (TIMEOUT != 0);
  localparam logic [TW-1:0] TO_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

  logic [1:0]    state;
  logic          grant;
  logic          last;
  logic          op_rd;
  logic [TW-1:0] cnt;
  logic [31:0]   lba_q;
  logic [1:0]    busy_q;
  logic [1:0]    done_q;
  logic [1:0]    err_q;

  logic [1:0]    cand;
  logic          pick;
  logic          timeout_hit;
  logic [1:0]    grant_vec;

  // On a tie the client that was not served last wins.
  always_comb begin
    cand        = bus.req_rd | bus.req_wr;
    pick        = (cand == 2'b11) ? ~last : cand[1];
    timeout_hit = TO_EN && (cnt == TO_LAST);
    grant_vec   = {grant, ~grant};
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      grant  <= 1'b0;
      last   <= 1'b1;
      op_rd  <= 1'b0;
      cnt    <= '0;
      lba_q  <= '0;
      busy_q <= '0;
      done_q <= '0;
      err_q  <= '0;
    end else begin
      done_q <= '0;
      err_q  <= '0;
      case (state)
        S_IDLE: begin
          if (|cand) begin
            grant        <= pick;
            lba_q        <= pick ? bus.req_lba1 : bus.req_lba0;
            op_rd        <= bus.req_rd[pick];
            busy_q[pick] <= 1'b1;
            cnt          <= '0;
            state        <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cnt <= cnt + 1'b1;
          if (bus.sd_ack) begin
            state <= S_XFER;
          end else if (timeout_hit) begin
            // Abort: the completion pulse is issued here, so DONE stays quiet.
            done_q[grant] <= 1'b1;
            err_q[grant]  <= 1'b1;
            state         <= S_DONE;
          end
        end
        S_XFER: begin
          if (!bus.sd_ack) begin
            done_q[grant] <= 1'b1;
            state         <= S_DONE;
          end
        end
        S_DONE: begin
          busy_q[grant] <= 1'b0;
          last          <= grant;
          cnt           <= '0;
          state         <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;
  assign bus.sd_lba      = lba_q;
  assign bus.sd_rd       = (state == S_ISSUE &&  op_rd) ? grant_vec : 2'b00;
  assign bus.sd_wr       = (state == S_ISSUE && !op_rd) ? grant_vec : 2'b00;
  assign bus.buf_wr      = (state == S_XFER && bus.sd_buff_wr) ? grant_vec : 2'b00;
  assign bus.sd_buff_din = (state == S_IDLE) ? 8'h00 : (grant ? bus.buf_din1 : bus.buf_din0);

endmodule

// File: tb/tb_sd_slot_arbiter.sv
// Directed self-checking bench for sd_slot_arbiter: single read, tie-break,
// fairness, write-data mux, ack timeout and asynchronous reset mid-transfer.
module tb_sd_slot_arbiter;
  logic clk_sys = 1'b0;
  logic reset;
  int   num_compared   = 0;
  int   num_mismatched = 0;

  logic [1:0] granted;
  int         pulses0;
  int         pulses1;
  int         hi_cycles;

  sd_slot_arbiter_if bus();

  sd_slot_arbiter #(.TIMEOUT(16), .TW(8)) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .bus     (bus.master)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    num_compared++;
    if (observed !== expected) begin
      num_mismatched++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic cycle();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] rd, input logic [1:0] wr);
    bus.req_rd = rd;
    bus.req_wr = wr;
  endtask

  // Bounded wait for a request strobe; returns 0 if nothing is issued.
  task automatic waitIssue(output logic [1:0] g);
    g = 2'b00;
    for (int n = 0; n < 8; n++) begin
      cycle();
      if ((bus.sd_rd | bus.sd_wr) != 2'b00) begin
        g = bus.sd_rd | bus.sd_wr;
        break;
      end
    end
  endtask

  // Leaves the bench in the DONE cycle, where done is visible.
  task automatic ackHandshake();
    bus.sd_ack = 1'b1;
    cycle();
    bus.sd_ack = 1'b0;
    cycle();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset          = 1'b1;
    bus.req_rd     = '0;
    bus.req_wr     = '0;
    bus.req_lba0   = '0;
    bus.req_lba1   = '0;
    bus.buf_din0   = 8'h11;
    bus.buf_din1   = 8'h22;
    bus.sd_ack     = 1'b0;
    bus.sd_buff_wr = 1'b0;
    cycle();
    cycle();
    checkOutput("rst_busy", bus.busy, 2'b00);
    checkOutput("rst_rd", bus.sd_rd, 2'b00);
    reset = 1'b0;
    cycle();
    checkOutput("rst_after_done", bus.done, 2'b00);
    checkOutput("rst_after_din", bus.sd_buff_din, 8'h00);

    // Single read from client 0 with 512 byte strobes.
    applyStimulus(2'b01, 2'b00);
    bus.req_lba0 = 32'h1234;
    cycle();
    checkOutput("t1_rd", bus.sd_rd, 2'b01);
    checkOutput("t1_lba", bus.sd_lba, 32'h0000_1234);
    checkOutput("t1_busy", bus.busy, 2'b01);
    checkOutput("t1_din", bus.sd_buff_din, 8'h11);
    bus.sd_ack = 1'b1;
    cycle();
    checkOutput("t1_rd_drop", bus.sd_rd, 2'b00);
    pulses0 = 0;
    pulses1 = 0;
    for (int i = 0; i < 599; i++) begin
      bus.sd_buff_wr = (i >= 40 && i < 552);
      #1;
      if (bus.buf_wr[0]) pulses0++;
      if (bus.buf_wr[1]) pulses1++;
      cycle();
    end
    bus.sd_buff_wr = 1'b0;
    bus.sd_ack     = 1'b0;
    cycle();
    checkOutput("t1_done", bus.done, 2'b01);
    checkOutput("t1_err", bus.err, 2'b00);
    checkOutput("t1_pulses0", pulses0, 512);
    checkOutput("t1_pulses1", pulses1, 0);
    applyStimulus(2'b00, 2'b00);
    cycle();
    checkOutput("t1_done_end", bus.done, 2'b00);
    checkOutput("t1_busy_end", bus.busy, 2'b00);

    // Stray ack and strobe while idle must be ignored.
    bus.sd_ack     = 1'b1;
    bus.sd_buff_wr = 1'b1;
    #1;
    checkOutput("idle_bufwr", bus.buf_wr, 2'b00);
    cycle();
    checkOutput("idle_rd", bus.sd_rd, 2'b00);
    checkOutput("idle_busy", bus.busy, 2'b00);
    bus.sd_ack     = 1'b0;
    bus.sd_buff_wr = 1'b0;
    cycle();

    // Simultaneous requests straight out of reset.
    reset = 1'b1;
    cycle();
    applyStimulus(2'b11, 2'b00);
    bus.req_lba1 = 32'h0000_5678;
    #1;
    checkOutput("t2_rst_lba", bus.sd_lba, 32'h0);
    checkOutput("t2_rst_rd", bus.sd_rd, 2'b00);
    reset = 1'b0;
    cycle();
    checkOutput("t2_first", bus.sd_rd, 2'b01);
    checkOutput("t2_lba0", bus.sd_lba, 32'h0000_1234);
    ackHandshake();
    checkOutput("t2_done0", bus.done, 2'b01);
    applyStimulus(2'b10, 2'b00);
    cycle();
    checkOutput("t2_gap", bus.sd_rd, 2'b00);
    cycle();
    checkOutput("t2_second", bus.sd_rd, 2'b10);
    checkOutput("t2_lba1", bus.sd_lba, 32'h0000_5678);
    ackHandshake();
    checkOutput("t2_done1", bus.done, 2'b10);
    applyStimulus(2'b00, 2'b00);
    cycle();

    // Fairness: client 0 holds, client 1 joins mid-transaction.
    applyStimulus(2'b01, 2'b00);
    waitIssue(granted);
    checkOutput("t3_grant0", granted, 2'b01);
    applyStimulus(2'b11, 2'b00);
    ackHandshake();
    for (int k = 1; k < 4; k++) begin
      waitIssue(granted);
      checkOutput($sformatf("t3_grant%0d", k), granted, (k % 2 == 1) ? 2'b10 : 2'b01);
      ackHandshake();
    end
    applyStimulus(2'b00, 2'b00);
    cycle();
    cycle();

    // Write from client 1: data mux must follow the grant.
    applyStimulus(2'b00, 2'b10);
    bus.buf_din0 = 8'h3C;
    bus.buf_din1 = 8'hA5;
    bus.req_lba1 = 32'hDEAD_BEEF;
    cycle();
    checkOutput("t4_wr", bus.sd_wr, 2'b10);
    checkOutput("t4_rd", bus.sd_rd, 2'b00);
    checkOutput("t4_din_issue", bus.sd_buff_din, 8'hA5);
    checkOutput("t4_lba", bus.sd_lba, 32'hDEAD_BEEF);
    bus.sd_ack = 1'b1;
    cycle();
    bus.sd_buff_wr = 1'b1;
    #1;
    checkOutput("t4_bufwr", bus.buf_wr, 2'b10);
    checkOutput("t4_din_xfer", bus.sd_buff_din, 8'hA5);
    bus.sd_buff_wr = 1'b0;
    bus.sd_ack     = 1'b0;
    cycle();
    checkOutput("t4_done", bus.done, 2'b10);
    checkOutput("t4_din_done", bus.sd_buff_din, 8'hA5);
    applyStimulus(2'b00, 2'b00);
    cycle();
    checkOutput("t4_din_idle", bus.sd_buff_din, 8'h00);

    // Timeout with no ack at all.
    applyStimulus(2'b01, 2'b00);
    cycle();
    hi_cycles = 0;
    while (bus.sd_rd == 2'b01 && hi_cycles < 40) begin
      hi_cycles++;
      cycle();
    end
    checkOutput("t5_rd_cycles", hi_cycles, 16);
    checkOutput("t5_done", bus.done, 2'b01);
    checkOutput("t5_err", bus.err, 2'b01);
    applyStimulus(2'b00, 2'b00);
    cycle();
    checkOutput("t5_done_end", bus.done, 2'b00);
    checkOutput("t5_err_end", bus.err, 2'b00);
    checkOutput("t5_busy_end", bus.busy, 2'b00);
    applyStimulus(2'b10, 2'b00);
    cycle();
    checkOutput("t5_next", bus.sd_rd, 2'b10);
    ackHandshake();
    checkOutput("t5_next_done", bus.done, 2'b10);
    checkOutput("t5_next_err", bus.err, 2'b00);
    applyStimulus(2'b00, 2'b00);
    cycle();

    // Reset mid-XFER after client 0 was served last.
    applyStimulus(2'b01, 2'b00);
    cycle();
    ackHandshake();
    checkOutput("t6_pre_done", bus.done, 2'b01);
    applyStimulus(2'b00, 2'b00);
    cycle();
    applyStimulus(2'b10, 2'b00);
    cycle();
    checkOutput("t6_grant1", bus.sd_rd, 2'b10);
    bus.sd_ack = 1'b1;
    cycle();
    bus.sd_buff_wr = 1'b1;
    #1;
    checkOutput("t6_bufwr", bus.buf_wr, 2'b10);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("t6_rst_bufwr", bus.buf_wr, 2'b00);
    checkOutput("t6_rst_busy", bus.busy, 2'b00);
    checkOutput("t6_rst_lba", bus.sd_lba, 32'h0);
    checkOutput("t6_rst_din", bus.sd_buff_din, 8'h00);
    bus.sd_ack     = 1'b0;
    bus.sd_buff_wr = 1'b0;
    applyStimulus(2'b11, 2'b00);
    for (int k = 0; k < 3; k++) begin
      cycle();
      checkOutput($sformatf("t6_no_done%0d", k), bus.done, 2'b00);
    end
    reset = 1'b0;
    cycle();
    checkOutput("t6_first_grant", bus.sd_rd, 2'b01);
    checkOutput("t6_done_quiet", bus.done, 2'b00);
    ackHandshake();
    applyStimulus(2'b00, 2'b00);
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
    $finish;
  end
endmodule
